cond_unit: RTL and testbench

COND_UNIT -- requirements
Module: cond_unit

---
 rtl/cond_unit.sv | 95 +++++++++
 tb/tb_cond_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
// Condition check and flag register for the Execute stage, plus the E->M control pipeline register.
// Latency: CondExE/BranchTakenE are combinational; M-stage controls and Flags update one clock after an enabled Execute cycle.
// Backpressure: EnM=0 stalls the stage, so Flags and every M-stage register hold regardless of FlushE or FlagWE.
module cond_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] CondE,
  input  logic [1:0] FlagWE,
  input  logic [3:0] ALUFlags,
  input  logic       PCSrcE,
  input  logic       RegWriteE,
  input  logic       MemWriteE,
  input  logic       MemtoRegE,
  input  logic       NoWriteE,
  input  logic       EnM,
  input  logic       FlushE,
  output logic       CondExE,
  output logic       BranchTakenE,
  output logic       PCSrcM,
  output logic       RegWriteM,
  output logic       MemWriteM,
  output logic       MemtoRegM,
  output logic [3:0] Flags
);

  // Architectural flag bits, named for readability in the decode.
  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_pass;
  logic wr_nz, wr_cv;

  assign flag_n = Flags[3];
  assign flag_z = Flags[2];
  assign flag_c = Flags[1];
  assign flag_v = Flags[0];

  // Decode the condition field against the stored flags only; ALUFlags of
  // this cycle are deliberately not bypassed so the result stays registered-state based.
  always_comb begin
    cond_pass = 1'b0;
    case (CondE)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1000: cond_pass = flag_c & ~flag_z;
      4'b1001: cond_pass = ~flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      4'b1111: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

  // A bubble never passes its condition, which also blocks flag writes and
  // zeroes every gated control it would otherwise push into M.
  assign CondExE      = cond_pass & ~FlushE;
  assign BranchTakenE = PCSrcE & CondExE;

  // Flag halves are written independently and only when the stage advances.
  assign wr_nz = FlagWE[1] & CondExE & EnM;
  assign wr_cv = FlagWE[0] & CondExE & EnM;

  // Flag register: reset wins, otherwise each half loads from the ALU when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else begin
      if (wr_nz) Flags[3:2] <= ALUFlags[3:2];
      if (wr_cv) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  // E->M control register: loads gated controls on advance, holds on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      PCSrcM    <= 1'b0;
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
    end else if (EnM) begin
      PCSrcM    <= BranchTakenE;
      RegWriteM <= RegWriteE & CondExE & ~NoWriteE;
      MemWriteM <= MemWriteE & CondExE;
      MemtoRegM <= MemtoRegE & CondExE;
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit with a queue-based scoreboard.
// Stimulus drives one vector per cycle and pushes its hand-computed expectation.
// A negedge monitor pops and compares comb outputs plus current Flags/M-stage state.
module tb_cond_unit;

  logic       clk;
  logic       reset;
  logic [3:0] CondE;
  logic [1:0] FlagWE;
  logic [3:0] ALUFlags;
  logic       PCSrcE, RegWriteE, MemWriteE, MemtoRegE, NoWriteE, EnM, FlushE;
  logic       CondExE, BranchTakenE;
  logic       PCSrcM, RegWriteM, MemWriteM, MemtoRegM;
  logic [3:0] Flags;

  cond_unit dut (
    .clk          (clk),
    .reset        (reset),
    .CondE        (CondE),
    .FlagWE       (FlagWE),
    .ALUFlags     (ALUFlags),
    .PCSrcE       (PCSrcE),
    .RegWriteE    (RegWriteE),
    .MemWriteE    (MemWriteE),
    .MemtoRegE    (MemtoRegE),
    .NoWriteE     (NoWriteE),
    .EnM          (EnM),
    .FlushE       (FlushE),
    .CondExE      (CondExE),
    .BranchTakenE (BranchTakenE),
    .PCSrcM       (PCSrcM),
    .RegWriteM    (RegWriteM),
    .MemWriteM    (MemWriteM),
    .MemtoRegM    (MemtoRegM),
    .Flags        (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int       id;
    logic     cex;
    logic     bt;
    logic [3:0] flags;
    logic [3:0] m;   // {PCSrcM, RegWriteM, MemWriteM, MemtoRegM}
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec_id = 0;

  task automatic chk(input string name, input int id, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec=%0d got=%b want=%b", name, id, act, exp);
    end
  endtask

  // Inputs {rst, cond, fwe, alu, pcs, rw, mw, mtr, nw, enm, fl}; expectations for this cycle.
  task automatic vec(input logic rst, input logic [3:0] cond, input logic [1:0] fwe,
                     input logic [3:0] alu, input logic pcs, input logic rw, input logic mw,
                     input logic mtr, input logic nw, input logic enm, input logic fl,
                     input logic e_cex, input logic e_bt, input logic [3:0] e_flags,
                     input logic [3:0] e_m);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; CondE = cond; FlagWE = fwe; ALUFlags = alu;
    PCSrcE = pcs; RegWriteE = rw; MemWriteE = mw; MemtoRegE = mtr;
    NoWriteE = nw; EnM = enm; FlushE = fl;
    vec_id++;
    e.id = vec_id; e.cex = e_cex; e.bt = e_bt; e.flags = e_flags; e.m = e_m;
    sb.push_back(e);
  endtask

  // Monitor: compares whenever the scoreboard holds an expectation for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("CondExE",      e.id, {3'b000, CondExE},      {3'b000, e.cex});
        chk("BranchTakenE", e.id, {3'b000, BranchTakenE}, {3'b000, e.bt});
        chk("Flags",        e.id, Flags,                  e.flags);
        chk("PCSrcM",       e.id, {3'b000, PCSrcM},       {3'b000, e.m[3]});
        chk("RegWriteM",    e.id, {3'b000, RegWriteM},    {3'b000, e.m[2]});
        chk("MemWriteM",    e.id, {3'b000, MemWriteM},    {3'b000, e.m[1]});
        chk("MemtoRegM",    e.id, {3'b000, MemtoRegM},    {3'b000, e.m[0]});
      end
    end
  end

  initial begin
    reset = 1'b1; CondE = 4'b0000; FlagWE = 2'b00; ALUFlags = 4'b0000;
    PCSrcE = 0; RegWriteE = 0; MemWriteE = 0; MemtoRegE = 0;
    NoWriteE = 0; EnM = 1; FlushE = 0;
    repeat (2) @(posedge clk);

    //   rst cond     fwe    alu     pcs rw mw mtr nw enm fl   cex bt flags    m
    // Reset state and basic decode
    vec(0, 4'b0000, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 1, 0,   0, 0, 4'b0000, 4'b0000);
    vec(0, 4'b1110, 2'b00, 4'b0000, 1, 0, 0, 0, 0, 1, 0,   1, 1, 4'b0000, 4'b0000);
    vec(0, 4'b1111, 2'b00, 4'b0000, 1, 1, 0, 0, 0, 1, 0,   0, 0, 4'b0000, 4'b1000);
    // Flag set then dependent conditional op back to back
    vec(0, 4'b1110, 2'b11, 4'b0100, 0, 0, 0, 0, 0, 1, 0,   1, 0, 4'b0000, 4'b0000);
    vec(0, 4'b0000, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 1, 0,   1, 0, 4'b0100, 4'b0000);
    // Clear flags, then write only C,V half
    vec(0, 4'b1110, 2'b11, 4'b0000, 0, 0, 0, 0, 0, 1, 0,   1, 0, 4'b0100, 4'b0100);
    vec(0, 4'b1110, 2'b01, 4'b1111, 0, 0, 0, 0, 0, 1, 0,   1, 0, 4'b0000, 4'b0000);
    // Failed condition blocks the flag write
    vec(0, 4'b1111, 2'b11, 4'b1100, 0, 0, 0, 0, 0, 1, 0,   0, 0, 4'b0011, 4'b0000);
    // Flags := 1000, then signed-compare branches
    vec(0, 4'b1110, 2'b11, 4'b1000, 0, 0, 0, 0, 0, 1, 0,   1, 0, 4'b0011, 4'b0000);
    vec(0, 4'b1011, 2'b00, 4'b0000, 1, 0, 0, 0, 0, 1, 0,   1, 1, 4'b1000, 4'b0000);
    vec(0, 4'b1010, 2'b00, 4'b0000, 1, 0, 0, 0, 0, 1, 0,   0, 0, 4'b1000, 4'b1000);
    // Load all M controls, then stall three cycles (last with flush)
    vec(0, 4'b1110, 2'b00, 4'b0000, 1, 1, 1, 1, 0, 1, 0,   1, 1, 4'b1000, 4'b0000);
    vec(0, 4'b1110, 2'b11, 4'b1111, 0, 1, 0, 0, 0, 0, 0,   1, 0, 4'b1000, 4'b1111);
    vec(0, 4'b1110, 2'b11, 4'b1111, 0, 1, 0, 0, 0, 0, 0,   1, 0, 4'b1000, 4'b1111);
    vec(0, 4'b1110, 2'b11, 4'b1111, 0, 1, 0, 0, 0, 0, 1,   0, 0, 4'b1000, 4'b1111);
    // Flush with advance zeroes M and skips the flag write
    vec(0, 4'b1110, 2'b11, 4'b1111, 1, 1, 1, 1, 0, 1, 1,   0, 0, 4'b1000, 4'b1111);
    // Compare-class op: no register write, flags written
    vec(0, 4'b1110, 2'b11, 4'b0110, 0, 1, 1, 0, 1, 1, 0,   1, 0, 4'b1000, 4'b0000);
    // Reset mid-stream: comb outputs still follow Flags; reset beats the flag write
    vec(1, 4'b0000, 2'b11, 4'b1111, 0, 1, 0, 0, 0, 1, 0,   1, 0, 4'b0110, 4'b0010);
    vec(0, 4'b0000, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 1, 0,   0, 0, 4'b0000, 4'b0000);
    // V-flag based conditions
    vec(0, 4'b1110, 2'b01, 4'b0001, 0, 0, 0, 0, 0, 1, 0,   1, 0, 4'b0000, 4'b0000);
    vec(0, 4'b0110, 2'b00, 4'b0000, 1, 0, 0, 0, 0, 1, 0,   1, 1, 4'b0001, 4'b0000);
    vec(0, 4'b1100, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 1, 0,   0, 0, 4'b0001, 4'b1000);
    vec(0, 4'b1001, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 1, 0,   1, 0, 4'b0001, 4'b0000);
    vec(0, 4'b1000, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 1, 0,   0, 0, 4'b0001, 4'b0000);

    // Give the monitor a bounded number of cycles to drain the queue.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
